// File: rtl/alu_wide_seq.sv
// alu_wide_seq: sequences NBYTES-wide add/sub/logic operations over an
// external 8-bit ALU, one byte per cycle, LSB first, chaining carry/borrow
// and folding the per-byte zero flags into one result flag.
//
// Optional build macro: ALU_WIDE_SEQ_OVF_EN adds the ovfF signed-overflow
// output. Without it the port and its logic are absent.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; ALU parked on OP_IDLE
// PASS  | one ALU pass per cycle on byte idx, LSB first
// DONE  | one-cycle done pulse; result/flags already valid
module alu_wide_seq #(
  parameter int NBYTES = 2,
  parameter logic [3:0] OP_IDLE = 4'b1111
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cInExt,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cOutF,
  output logic                  zeroF,
  output logic                  err,
`ifdef ALU_WIDE_SEQ_OVF_EN
  output logic                  ovfF,
`endif
  output logic [7:0]            aluIn1,
  output logic [7:0]            aluIn2,
  output logic                  aluCIn,
  output logic [2:0]            aluSc,
  output logic [3:0]            aluOpOut,
  input  logic [7:0]            aluOut,
  input  logic                  aluCOut,
  input  logic                  aluZero
);

  // Byte index width; NBYTES is limited to 2..4.
  localparam int IW = (NBYTES > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT state;
  stateT stateNext;

  logic [NBYTES-1:0][7:0] aQ;
  logic [NBYTES-1:0][7:0] bQ;
  logic [NBYTES-1:0][7:0] resWork;
  logic [NBYTES-1:0][7:0] resNext;
  logic [2:0]             opQ;
  logic                   cinQ;
  logic                   chainC;
  logic                   zeroAcc;
  logic [IW-1:0]          idx;
  logic                   lastIdx;
  logic                   isArith;
  logic                   isSub;

  // Only 0000..0011 are arithmetic; bit 1 selects subtract.
  assign isArith = ~opQ[2];
  assign isSub   = opQ[1];
  assign lastIdx = (idx == IW'(NBYTES - 1));
  assign aluSc   = 3'b000;

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode plus busy/done, which are pure functions of state.
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) stateNext = op[3] ? DONE : PASS;
      end
      PASS: begin
        busy = 1'b1;
        if (lastIdx) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // ALU drive: only active in PASS; upper bytes of add/sub always run the
  // carry-in variant so the chain carry/borrow propagates.
  always_comb begin
    aluOpOut = OP_IDLE;
    aluIn1   = 8'h00;
    aluIn2   = 8'h00;
    aluCIn   = 1'b0;
    if (state == PASS) begin
      aluIn1 = aQ[idx];
      aluIn2 = bQ[idx];
      if (isArith) begin
        if (idx == '0) begin
          aluOpOut = {1'b0, opQ};
          aluCIn   = opQ[0] ? cinQ : 1'b0;
        end else begin
          aluOpOut = isSub ? 4'b0011 : 4'b0001;
          aluCIn   = chainC;
        end
      end else begin
        aluOpOut = {1'b0, opQ};
      end
    end
  end

  // Working result with the current ALU byte merged in, used at the last pass.
  always_comb begin
    resNext      = resWork;
    resNext[idx] = aluOut;
  end

  // Operand capture, per-pass accumulation and end-of-operation result update.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      aQ      <= '0;
      bQ      <= '0;
      opQ     <= 3'b000;
      cinQ    <= 1'b0;
      chainC  <= 1'b0;
      zeroAcc <= 1'b0;
      idx     <= '0;
      resWork <= '0;
      result  <= '0;
      cOutF   <= 1'b0;
      zeroF   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (op[3]) begin
              err    <= 1'b1;
              result <= '0;
              cOutF  <= 1'b0;
              zeroF  <= 1'b0;
            end else begin
              aQ      <= a;
              bQ      <= b;
              opQ     <= op[2:0];
              cinQ    <= cInExt;
              idx     <= '0;
              zeroAcc <= 1'b1;
              chainC  <= 1'b0;
              resWork <= '0;
            end
          end
        end
        PASS: begin
          resWork[idx] <= aluOut;
          chainC       <= aluCOut;
          zeroAcc      <= zeroAcc & aluZero;
          idx          <= idx + 1'b1;
          if (lastIdx) begin
            idx    <= '0;
            result <= resNext;
            cOutF  <= isArith & aluCOut;
            zeroF  <= zeroAcc & aluZero;
            err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_WIDE_SEQ_OVF_EN
  logic ovfNext;
  logic aSign;
  logic bSign;
  logic rSign;

  assign aSign = aQ[NBYTES-1][7];
  assign bSign = bQ[NBYTES-1][7];
  assign rSign = aluOut[7];

  // Signed overflow from the top-byte signs at the final pass.
  always_comb begin
    ovfNext = 1'b0;
    if (isArith) begin
      if (isSub) ovfNext = (aSign != bSign) && (rSign != aSign);
      else       ovfNext = (aSign == bSign) && (rSign != aSign);
    end
  end

  // Overflow flag is updated alongside the other result flags.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ovfF <= 1'b0;
    end else if (state == IDLE && start && op[3]) begin
      ovfF <= 1'b0;
    end else if (state == PASS && lastIdx) begin
      ovfF <= ovfNext;
    end
  end
`endif

endmodule
